// File: rtl/mmu_feeder.sv
// mmu_feeder: snapshots A/B on a start edge, feeds a 2x2 output-stationary array with
// diagonal skew, then serializes the four accumulators. Optional macro FEEDER_RELU_EN clamps negative results to 0.
module mmu_feeder #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  feeding_en,
   input  logic [8*DATA_W-1:0]   mem_flat,
   input  logic [ACC_W-1:0]      c00,
   input  logic [ACC_W-1:0]      c01,
   input  logic [ACC_W-1:0]      c10,
   input  logic [ACC_W-1:0]      c11,
   output logic [DATA_W-1:0]     a_in0,
   output logic [DATA_W-1:0]     a_in1,
   output logic [DATA_W-1:0]     b_in0,
   output logic [DATA_W-1:0]     b_in1,
   output logic                  pe_clear,
   output logic                  busy,
   output logic [ACC_W-1:0]      out_data,
   output logic                  out_valid,
   output logic                  done
);

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN} state_t;

   state_t                 state, state_nxt;
   logic [1:0]             step, step_nxt;
   logic                   en_d;
   // a00/b00 go straight out at the start edge, so only the six later elements are held
   logic [5:0][DATA_W-1:0] snap, snap_nxt;
   logic [DATA_W-1:0]      a0_nxt, a1_nxt, b0_nxt, b1_nxt;
   logic                   clear_nxt, busy_nxt, valid_nxt, done_nxt;
   logic [ACC_W-1:0]       data_nxt;

   function automatic logic [DATA_W-1:0] elem(input logic [8*DATA_W-1:0] v, input int k);
      return v[k*DATA_W +: DATA_W];
   endfunction

   function automatic logic [ACC_W-1:0] shape(input logic [ACC_W-1:0] v);
`ifdef FEEDER_RELU_EN
      return v[ACC_W-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         step      <= '0;
         en_d      <= 1'b0;
         snap      <= '0;
         a_in0     <= '0;
         a_in1     <= '0;
         b_in0     <= '0;
         b_in1     <= '0;
         pe_clear  <= 1'b0;
         busy      <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         step      <= step_nxt;
         en_d      <= feeding_en;
         snap      <= snap_nxt;
         a_in0     <= a0_nxt;
         a_in1     <= a1_nxt;
         b_in0     <= b0_nxt;
         b_in1     <= b1_nxt;
         pe_clear  <= clear_nxt;
         busy      <= busy_nxt;
         out_data  <= data_nxt;
         out_valid <= valid_nxt;
         done      <= done_nxt;
      end
   end

   // The last drain step returns to S_IDLE so a start sampled one cycle later is accepted
   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      snap_nxt  = snap;
      a0_nxt    = '0;
      a1_nxt    = '0;
      b0_nxt    = '0;
      b1_nxt    = '0;
      clear_nxt = 1'b0;
      busy_nxt  = 1'b0;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      data_nxt  = out_data;
      case (state)
         S_IDLE: begin
            if (feeding_en && !en_d) begin
               snap_nxt  = {elem(mem_flat, 7), elem(mem_flat, 6), elem(mem_flat, 5),
                            elem(mem_flat, 3), elem(mem_flat, 2), elem(mem_flat, 1)};
               a0_nxt    = elem(mem_flat, 0);
               b0_nxt    = elem(mem_flat, 4);
               clear_nxt = 1'b1;
               busy_nxt  = 1'b1;
               state_nxt = S_FEED;
               step_nxt  = 2'd1;
            end
         end
         S_FEED: begin
            busy_nxt = 1'b1;
            case (step)
               2'd1: begin
                  a0_nxt   = snap[0];
                  a1_nxt   = snap[1];
                  b0_nxt   = snap[4];
                  b1_nxt   = snap[3];
                  step_nxt = 2'd2;
               end
               2'd2: begin
                  a1_nxt   = snap[2];
                  b1_nxt   = snap[5];
                  step_nxt = 2'd3;
               end
               default: begin
                  valid_nxt = 1'b1;
                  data_nxt  = shape(c00);
                  state_nxt = S_DRAIN;
                  step_nxt  = 2'd1;
               end
            endcase
         end
         S_DRAIN: begin
            busy_nxt  = 1'b1;
            valid_nxt = 1'b1;
            case (step)
               2'd1: begin
                  data_nxt = shape(c01);
                  step_nxt = 2'd2;
               end
               2'd2: begin
                  data_nxt = shape(c10);
                  step_nxt = 2'd3;
               end
               default: begin
                  data_nxt  = shape(c11);
                  done_nxt  = 1'b1;
                  state_nxt = S_IDLE;
                  step_nxt  = 2'd0;
               end
            endcase
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mmu_feeder.sv
// tb_mmu_feeder: drives mmu_feeder against a behavioural 2x2 systolic array and
// checks every cycle against a phase-based model plus hand-computed literals.
module tb_mmu_feeder;
   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;
   localparam logic [63:0] MEM_A = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
   localparam logic [63:0] MEM_I = {8'd6, 8'd7, 8'd8, 8'd9, 8'd1, 8'd0, 8'd0, 8'd1};
`ifdef FEEDER_RELU_EN
   localparam logic [15:0] EXP_NEG = 16'h0000;
   localparam logic [15:0] EXP_FF  = 16'h0000;
`else
   localparam logic [15:0] EXP_NEG = 16'hFFF6;
   localparam logic [15:0] EXP_FF  = 16'hFC02;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        feeding_en = 1'b0;
   logic [63:0] mem_flat = '0;
   logic        override = 1'b0;
   logic [15:0] c00, c01, c10, c11;
   logic [7:0]  a_in0, a_in1, b_in0, b_in1;
   logic        pe_clear, busy, out_valid, done;
   logic [15:0] out_data;
   int          n_err = 0;
   int          n_chk = 0;

   mmu_feeder #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .feeding_en(feeding_en), .mem_flat(mem_flat),
      .c00(c00), .c01(c01), .c10(c10), .c11(c11),
      .a_in0(a_in0), .a_in1(a_in1), .b_in0(b_in0), .b_in1(b_in1),
      .pe_clear(pe_clear), .busy(busy), .out_data(out_data),
      .out_valid(out_valid), .done(done)
   );

   always #5 clk = ~clk;

   // Behavioural array: a moves right and b moves down through one register per PE
   logic [15:0] acc00, acc01, acc10, acc11;
   logic [7:0]  a_fwd0, a_fwd1, b_fwd0, b_fwd1;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
         a_fwd0 <= '0; a_fwd1 <= '0; b_fwd0 <= '0; b_fwd1 <= '0;
      end else begin
         a_fwd0 <= a_in0;
         a_fwd1 <= a_in1;
         b_fwd0 <= b_in0;
         b_fwd1 <= b_in1;
         acc00 <= (pe_clear ? 16'd0 : acc00) + 16'(a_in0) * 16'(b_in0);
         acc01 <= (pe_clear ? 16'd0 : acc01) + 16'(a_fwd0) * 16'(b_in1);
         acc10 <= (pe_clear ? 16'd0 : acc10) + 16'(a_in1) * 16'(b_fwd0);
         acc11 <= (pe_clear ? 16'd0 : acc11) + 16'(a_fwd1) * 16'(b_fwd1);
      end
   end
   assign c00 = override ? 16'd3    : acc00;
   assign c01 = override ? 16'hFFF6 : acc01;
   assign c10 = override ? 16'd3    : acc10;
   assign c11 = override ? 16'd3    : acc11;

   // Model: m_phase counts edges since the accepted start, -1 when idle
   int          m_phase = -1;
   logic        m_en_d = 1'b0;
   logic [63:0] m_snap = '0;
   logic [15:0] m_last = '0;

   function automatic logic [15:0] elem_v(input int k);
      return {8'd0, m_snap[k*8 +: 8]};
   endfunction

   function automatic logic [15:0] model_res(input int i);
      logic [15:0] v;
      int r, c;
      r = i / 2;
      c = i % 2;
      if (override) v = (i == 1) ? 16'hFFF6 : 16'd3;
      else          v = elem_v(2*r) * elem_v(4+c) + elem_v(2*r+1) * elem_v(6+c);
`ifdef FEEDER_RELU_EN
      if (v[15]) v = 16'd0;
`endif
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= -1;
         m_en_d  <= 1'b0;
         m_snap  <= '0;
         m_last  <= '0;
      end else begin
         m_en_d <= feeding_en;
         if (m_phase == 5) m_last <= model_res(3);
         if (feeding_en && !m_en_d && (m_phase < 0 || m_phase == 6)) begin
            m_phase <= 0;
            m_snap  <= mem_flat;
         end else if (m_phase >= 0 && m_phase < 6) begin
            m_phase <= m_phase + 1;
         end else begin
            m_phase <= -1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compareModel();
      logic [7:0] ea0, ea1, eb0, eb1;
      logic       eclr;
      ea0 = '0; ea1 = '0; eb0 = '0; eb1 = '0; eclr = 1'b0;
      case (m_phase)
         0: begin ea0 = m_snap[7:0]; eb0 = m_snap[39:32]; eclr = 1'b1; end
         1: begin ea0 = m_snap[15:8]; ea1 = m_snap[23:16]; eb0 = m_snap[55:48]; eb1 = m_snap[47:40]; end
         2: begin ea1 = m_snap[31:24]; eb1 = m_snap[63:56]; end
         default: ;
      endcase
      checkOutput("a_in0", 16'(a_in0), 16'(ea0));
      checkOutput("a_in1", 16'(a_in1), 16'(ea1));
      checkOutput("b_in0", 16'(b_in0), 16'(eb0));
      checkOutput("b_in1", 16'(b_in1), 16'(eb1));
      checkOutput("pe_clear", 16'(pe_clear), 16'(eclr));
      checkOutput("busy", 16'(busy), 16'(m_phase >= 0));
      checkOutput("out_valid", 16'(out_valid), 16'(m_phase >= 3));
      checkOutput("done", 16'(done), 16'(m_phase == 6));
      checkOutput("out_data", out_data, (m_phase >= 3) ? model_res(m_phase - 3) : m_last);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         compareModel();
      end
   end

   task automatic applyStimulus(input logic [63:0] mem, input logic en);
      @(negedge clk);
      mem_flat   = mem;
      feeding_en = en;
   endtask

   task automatic checkFeed(input string name, input logic [7:0] ea0, input logic [7:0] ea1,
                            input logic [7:0] eb0, input logic [7:0] eb1);
      checkOutput({name, "_a0"}, 16'(a_in0), 16'(ea0));
      checkOutput({name, "_a1"}, 16'(a_in1), 16'(ea1));
      checkOutput({name, "_b0"}, 16'(b_in0), 16'(eb0));
      checkOutput({name, "_b1"}, 16'(b_in1), 16'(eb1));
   endtask

   initial begin
      $display("[TB] mmu_feeder bench starting");
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic multiply and feed skew
      applyStimulus(MEM_A, 1'b1);
      applyStimulus(MEM_A, 1'b0);
      checkFeed("skew0", 8'd1, 8'd0, 8'd5, 8'd0);
      checkOutput("skew0_clear", 16'(pe_clear), 16'd1);
      @(negedge clk);
      checkFeed("skew1", 8'd2, 8'd3, 8'd7, 8'd6);
      checkOutput("skew1_clear", 16'(pe_clear), 16'd0);
      @(negedge clk);
      checkFeed("skew2", 8'd0, 8'd4, 8'd0, 8'd8);
      @(negedge clk);
      checkFeed("skew3", 8'd0, 8'd0, 8'd0, 8'd0);
      checkOutput("basic_r0", out_data, 16'd19);
      checkOutput("basic_v0", 16'(out_valid), 16'd1);
      @(negedge clk);
      checkOutput("basic_r1", out_data, 16'd22);
      @(negedge clk);
      checkOutput("basic_r2", out_data, 16'd43);
      @(negedge clk);
      checkOutput("basic_r3", out_data, 16'd50);
      checkOutput("basic_done", 16'(done), 16'd1);
      @(negedge clk);
      checkOutput("basic_idle_busy", 16'(busy), 16'd0);
      checkOutput("basic_idle_valid", 16'(out_valid), 16'd0);
      checkOutput("basic_hold", out_data, 16'd50);

      // Snapshot with memory changing after start, and level-held feeding_en
      applyStimulus(MEM_A, 1'b1);
      @(negedge clk);
      mem_flat = '1;
      @(negedge clk);
      checkFeed("snap1", 8'd2, 8'd3, 8'd7, 8'd6);
      repeat (2) @(negedge clk);
      checkOutput("snap_r0", out_data, 16'd19);
      repeat (3) @(negedge clk);
      checkOutput("snap_r3", out_data, 16'd50);
      repeat (14) @(negedge clk);
      checkOutput("hold_no_restart", 16'(busy), 16'd0);
      feeding_en = 1'b0;
      @(negedge clk);
      feeding_en = 1'b1;
      @(negedge clk);
      feeding_en = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("ff_r0", out_data, EXP_FF);
      repeat (4) @(negedge clk);

      // Back-to-back: restart sampled on the edge right after done
      applyStimulus(MEM_A, 1'b1);
      applyStimulus(MEM_I, 1'b0);
      repeat (6) @(negedge clk);
      checkOutput("b2b_first_done", 16'(done), 16'd1);
      feeding_en = 1'b1;
      @(negedge clk);
      feeding_en = 1'b0;
      checkOutput("b2b_busy", 16'(busy), 16'd1);
      checkOutput("b2b_clear", 16'(pe_clear), 16'd1);
      repeat (3) @(negedge clk);
      checkOutput("b2b_r0", out_data, 16'd9);
      @(negedge clk);
      checkOutput("b2b_r1", out_data, 16'd8);
      @(negedge clk);
      checkOutput("b2b_r2", out_data, 16'd7);
      @(negedge clk);
      checkOutput("b2b_r3", out_data, 16'd6);
      repeat (2) @(negedge clk);

      // Reset in the middle of the drain
      applyStimulus(MEM_A, 1'b1);
      applyStimulus(MEM_A, 1'b0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_data", out_data, 16'd0);
      checkOutput("rst_valid", 16'(out_valid), 16'd0);
      checkOutput("rst_busy", 16'(busy), 16'd0);
      checkOutput("rst_done", 16'(done), 16'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      checkOutput("rst_quiet", 16'(out_valid), 16'd0);
      applyStimulus(MEM_I, 1'b1);
      applyStimulus(MEM_I, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("rst_rerun_r0", out_data, 16'd9);
      repeat (4) @(negedge clk);

      // Negative accumulator: clamped only when the ReLU build is selected
      override = 1'b1;
      applyStimulus(MEM_A, 1'b1);
      applyStimulus(MEM_A, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("relu_r0", out_data, 16'd3);
      @(negedge clk);
      checkOutput("relu_r1", out_data, EXP_NEG);
      @(negedge clk);
      checkOutput("relu_r2", out_data, 16'd3);
      @(negedge clk);
      checkOutput("relu_r3", out_data, 16'd3);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mmu_feeder.md
Name: mmu_feeder

Overview:
- Sits between the weight/input memory and the 2x2 output-stationary systolic MMU.
- On a start edge it snapshots the 8 stored elements (A and B, row-major) and injects them onto the array edges with diagonal skew.
- It then reads back the four accumulators and presents them one per cycle on a single result port.
- Self-timed: runs its own feed/drain schedule and needs no per-cycle sequencing from the controller.

Parameters:
- DATA_W, 8, width of each matrix element.
- ACC_W, 16, width of each PE accumulator and of out_data.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- feeding_en  in  1  start request; a rising edge (sampled while idle) launches one operation
- mem_flat  in  8*DATA_W  memory contents; element k at bits [8k+7:8k]: k0=a00, k1=a01, k2=a10, k3=a11, k4=b00, k5=b01, k6=b10, k7=b11
- c00, c01, c10, c11  in  ACC_W each  PE accumulator values from the array
- a_in0, a_in1  out  DATA_W  left-edge inputs, rows 0/1
- b_in0, b_in1  out  DATA_W  top-edge inputs, columns 0/1
- pe_clear  out  1  PEs load a*b instead of acc+a*b this cycle
- busy  out  1  operation in progress
- out_data  out  ACC_W  serialized result
- out_valid  out  1  out_data valid this cycle
- done  out  1  one-cycle pulse coincident with the final result

Behaviour:
- Reset: all outputs 0, state S_IDLE, snapshot registers 0, en_d 0, counters 0. Reset at any point aborts the operation; no partial results are emitted afterwards.
- Start condition: feeding_en=1 and en_d=0 and state=S_IDLE.
  - en_d is feeding_en registered each cycle.
  - Rising edges while busy are ignored.
  - feeding_en falling mid-operation is ignored.
  - Holding feeding_en high after done does not restart; it must go low then high again.
- Timing notation: E = the clock edge at which the start condition is sampled true. All outputs are registered.
- S_IDLE: a/b outputs 0, pe_clear 0, busy 0. On start, at E:
  - snapshot mem_flat;
  - drive step 0: a_in0=a00, a_in1=0, b_in0=b00, b_in1=0, pe_clear=1, busy=1;
  - go to S_FEED with step=1.
- S_FEED steps (values are taken from the snapshot, so memory may change after E):
  - Edge E+1, step 1: a_in0=a01, a_in1=a10, b_in0=b10, b_in1=b01, pe_clear=0.
  - Edge E+2, step 2: a_in0=0, a_in1=a11, b_in0=0, b_in1=b11.
  - Edge E+3: all a/b outputs 0. Go to S_DRAIN; a/b stay 0 until the next start.
- S_DRAIN capture schedule:
  - out_data<=c00 at E+3, c01 at E+4, c10 at E+5, c11 at E+6.
  - out_valid=1 for exactly those four cycles.
  - done=1 only in the cycle following E+6, alongside c11.
  - At E+7: out_valid=0, done=0, busy=0, state=S_IDLE. out_data holds the last value until the next operation.
- Earliest legal restart: a start sampled at E+7 is accepted, provided feeding_en went low at some point.
- Results are passed through unmodified at ACC_W width; the block does no arithmetic except under the optional feature.
- Array contract: PEs forward a rightward and b downward through one register each, and hold their accumulators stable between operations (zero inputs add 0).

Optional Feature:
- Macro: FEEDER_RELU_EN.
- When defined: each captured result is interpreted as signed ACC_W. If its MSB is 1, out_data=0; otherwise the value passes through. Timing is unchanged.
- When undefined: raw passthrough, and no extra logic is compiled.

Test Plan:
- Basic multiply: A=[[1,2],[3,4]], B=[[5,6],[7,8]], behavioural 2x2 PE model, pulse feeding_en -> out_data 19, 22, 43, 50 at E+3..E+6, out_valid high for exactly those 4 cycles, done with 50, busy low from E+7.
- Feed skew: same data -> (a_in0, a_in1, b_in0, b_in1) = (1,0,5,0) with pe_clear=1 after E, (2,3,7,6) after E+1, (0,4,0,8) after E+2, then (0,0,0,0).
- Snapshot and level-hold: change mem_flat to all 0xFF at E+1 and hold feeding_en high for 20 cycles -> results still 19/22/43/50 and exactly one operation runs; dropping and re-raising feeding_en starts a second run that uses 0xFF data.
- Back-to-back: A=I, B=[[9,8],[7,6]] restarted at E+7 right after a first run -> second run outputs 9, 8, 7, 6 with no stale accumulation, because pe_clear asserts again.
- Reset mid-operation: assert rst_n=0 at E+4 -> all outputs 0 immediately; after release, no out_valid until a new rising edge of feeding_en.
- RELU (FEEDER_RELU_EN defined): model returns c01=16'hFFF6 (-10), others 3 -> out_data 3, 0, 3, 3. With the macro undefined -> 3, 0xFFF6, 3, 3.
